// File: rtl/ysyx_23060136_DEFINES.sv
// ============================================================================
// Module  : ysyx_23060136_DEFINES
// Brief   : Shared AXI encodings and responder FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_23060136_DEFINES;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_23060136_axi_rd_responder_if.sv
// ============================================================================
// Module  : ysyx_23060136_axi_rd_responder_if
// Brief   : AXI4 read channel (AR + R) bundle with master/slave views.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_23060136_axi_rd_responder_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_23060136_axi_addr_gen.sv
// ============================================================================
// Module  : ysyx_23060136_axi_addr_gen
// Brief   : Combinational AXI next-beat address and burst-format legality.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060136_axi_addr_gen
    import ysyx_23060136_DEFINES::*;
(
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        fmt_err
);

    logic [31:0] step;
    logic [31:0] mask;
    logic        wrap_len_ok;
    logic        aligned;

    assign step        = 32'd1 << size;
    assign mask        = (({24'd0, len} + 32'd1) << size) - 32'd1;
    assign wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    assign aligned     = (addr & (step - 32'd1)) == 32'd0;

    always_comb begin
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = addr + step;
            BURST_WRAP: next_addr = (addr & ~mask) | ((addr + step) & mask);
            default:    next_addr = addr;
        endcase
    end

    // Range checks live in the responder; this covers encoding-level faults only.
    assign fmt_err = (size > 3'd3) || (burst == BURST_RSVD) ||
                     ((burst == BURST_WRAP) && (!wrap_len_ok || !aligned));

endmodule

`default_nettype wire

// File: rtl/ysyx_23060136_axi_rd_responder.sv
// ============================================================================
// Module  : ysyx_23060136_axi_rd_responder
// Brief   : AXI4 read-only burst responder over a preloadable 64-bit memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060136_axi_rd_responder
    import ysyx_23060136_DEFINES::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          RD_DELAY  = 2,
    localparam int         IDX_W     = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_23060136_axi_rd_responder_if.slave axi,
    input  logic                          init_we,
    input  logic [IDX_W-1:0]              init_idx,
    input  logic [63:0]                   init_wdata
);

    localparam logic [32:0] SPAN = 33'(DEPTH) << 3;

    rd_state_t   state;
    logic [31:0] addr_r;
    logic [3:0]  id_r;
    logic [7:0]  len_r;
    logic [2:0]  size_r;
    logic [1:0]  burst_r;
    logic        err_r;
    logic [3:0]  cnt;
    logic [8:0]  issued;
    logic [63:0] mem [DEPTH];

    logic        idle;
    logic        ar_hs;
    logic [31:0] cur_addr;
    logic [3:0]  cur_id;
    logic [7:0]  cur_len;
    logic [2:0]  cur_size;
    logic [1:0]  cur_burst;
    logic [31:0] next_addr;
    logic        fmt_err;
    logic        cur_err;
    logic        beat_err;
    logic [IDX_W-1:0] beat_idx;
    logic        first;
    logic        load;
    logic        last;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return {1'b0, off} < SPAN;
    endfunction

    // In IDLE the AR payload feeds the beat path directly so a zero delay
    // can load the first beat on the handshake edge itself.
    assign idle      = (state == IDLE);
    assign ar_hs     = idle && axi.arvalid && axi.arready;
    assign cur_addr  = idle ? axi.araddr  : addr_r;
    assign cur_id    = idle ? axi.arid    : id_r;
    assign cur_len   = idle ? axi.arlen   : len_r;
    assign cur_size  = idle ? axi.arsize  : size_r;
    assign cur_burst = idle ? axi.arburst : burst_r;

    ysyx_23060136_axi_addr_gen u_addr_gen (
        .addr      (cur_addr),
        .len       (cur_len),
        .size      (cur_size),
        .burst     (cur_burst),
        .next_addr (next_addr),
        .fmt_err   (fmt_err)
    );

    // Whole-burst error is fixed at acceptance; per-beat range catches INCR overrun.
    assign cur_err  = idle ? (fmt_err || !in_range(axi.araddr)) : err_r;
    assign beat_err = cur_err || !in_range(cur_addr);
    assign beat_idx = IDX_W'((cur_addr - BASE_ADDR) >> 3);

    assign first = (state != BURST);
    assign load  = (ar_hs && (RD_DELAY == 0)) ||
                   ((state == WAIT) && (cnt == 4'd1)) ||
                   ((state == BURST) && (!axi.rvalid || axi.rready) &&
                    (issued <= {1'b0, len_r}));
    assign last  = ((first ? 9'd0 : issued) == {1'b0, cur_len});

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_idx] <= init_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            axi.arready <= 1'b1;
            axi.rvalid  <= 1'b0;
            axi.rdata   <= 64'd0;
            axi.rresp   <= RESP_OKAY;
            axi.rlast   <= 1'b0;
            axi.rid     <= 4'd0;
            addr_r      <= 32'd0;
            id_r        <= 4'd0;
            len_r       <= 8'd0;
            size_r      <= 3'd0;
            burst_r     <= 2'd0;
            err_r       <= 1'b0;
            cnt         <= 4'd0;
            issued      <= 9'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        addr_r      <= axi.araddr;
                        id_r        <= axi.arid;
                        len_r       <= axi.arlen;
                        size_r      <= axi.arsize;
                        burst_r     <= axi.arburst;
                        err_r       <= cur_err;
                        cnt         <= 4'(RD_DELAY);
                        axi.arready <= 1'b0;
                        state       <= (RD_DELAY == 0) ? BURST : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (axi.rvalid && axi.rready && axi.rlast) begin
                        axi.arready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Beat register; placed after the FSM so its addr_r update wins.
            if (load) begin
                axi.rvalid <= 1'b1;
                axi.rdata  <= beat_err ? 64'd0 : mem[beat_idx];
                axi.rresp  <= beat_err ? RESP_SLVERR : RESP_OKAY;
                axi.rlast  <= last;
                axi.rid    <= cur_id;
                addr_r     <= next_addr;
                issued     <= first ? 9'd1 : issued + 9'd1;
            end else if (axi.rvalid && axi.rready) begin
                axi.rvalid <= 1'b0;
                axi.rlast  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060136_axi_rd_responder.sv
// ============================================================================
// Module  : tb_ysyx_23060136_axi_rd_responder
// Brief   : Scoreboard bench for the AXI read burst responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060136_axi_rd_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          D     = 2;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_we;
    logic [9:0]  init_idx;
    logic [63:0] init_wdata;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    hs_count = 0;
    int    last_hs_cyc = 0;
    logic  toggle = 1'b0;
    int    tog_ph = 0;
    beat_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_23060136_axi_rd_responder_if axi();

    ysyx_23060136_axi_rd_responder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .RD_DELAY  (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .axi        (axi),
        .init_we    (init_we),
        .init_idx   (init_idx),
        .init_wdata (init_wdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] data, input logic [1:0] resp,
                        input logic last, input logic [3:0] id);
        beat_t b;
        b.data = data; b.resp = resp; b.last = last; b.id = id;
        sb.push_back(b);
    endtask

    // Monitor: pops on every R handshake and checks payload stability under stall.
    initial begin
        logic  prev_stall;
        beat_t held;
        beat_t e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_data", axi.rdata, held.data);
                    chk("hold_ctl", {56'd0, axi.rvalid, axi.rresp, axi.rlast, axi.rid},
                        {56'd0, 1'b1, held.resp, held.last, held.id});
                end
                if (axi.rvalid && axi.rready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0h expected no beat", axi.rdata);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_data", axi.rdata, e.data);
                        chk("beat_resp", {62'd0, axi.rresp}, {62'd0, e.resp});
                        chk("beat_last", {63'd0, axi.rlast}, {63'd0, e.last});
                        chk("beat_id", {60'd0, axi.rid}, {60'd0, e.id});
                    end
                    hs_count++;
                    last_hs_cyc = cyc;
                end
                prev_stall  = axi.rvalid && !axi.rready;
                held.data   = axi.rdata;
                held.resp   = axi.rresp;
                held.last   = axi.rlast;
                held.id     = axi.rid;
            end
        end
    end

    // rready pattern 1,0,0 repeating while toggle is set.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (toggle) begin
                axi.rready = (tog_ph == 0);
                tog_ph = (tog_ph + 1) % 3;
            end
        end
    end

    task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int t);
        bit ok;
        ok = 1'b0;
        t  = 0;
        axi.arvalid = 1'b1; axi.araddr = addr; axi.arid = id;
        axi.arlen = len; axi.arsize = size; axi.arburst = burst;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (axi.arready) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ar_timeout: got arready 0 expected 1");
        end
        @(posedge clk);
        #1;
        axi.arvalid = 1'b0;
    endtask

    // Waits for n handshakes; returns in cycle F+1 and checks arready is back.
    task automatic wait_burst(input int start, input int n);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (hs_count >= start + n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout: got %0d beats expected %0d", hs_count - start, n);
        end else begin
            chk("arready_after", {63'd0, axi.arready}, 64'd1);
            chk("rvalid_after", {63'd0, axi.rvalid}, 64'd0);
        end
    endtask

    initial begin
        int t;
        int start;
        int fv;
        axi.arvalid = 0; axi.araddr = 0; axi.arid = 0; axi.arlen = 0;
        axi.arsize = 0; axi.arburst = 0; axi.rready = 1'b1;
        init_we = 0; init_idx = 0; init_wdata = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_arready", {63'd0, axi.arready}, 64'd1);
        chk("rst_rvalid", {63'd0, axi.rvalid}, 64'd0);
        chk("rst_payload", {56'd0, axi.rresp, axi.rlast, axi.rid}, 64'd0);
        chk("rst_rdata", axi.rdata, 64'd0);

        for (int i = 0; i < 8; i++) begin
            init_we = 1'b1; init_idx = 10'(i); init_wdata = 64'(i * 'h11);
            tick();
        end
        init_idx = 10'd1022; init_wdata = 64'hCAFE_0000_0000_1022; tick();
        init_idx = 10'd1023; init_wdata = 64'hCAFE_0000_0000_1023; tick();
        init_we = 1'b0;
        tick();

        // INCR, 4 beats, latency and throughput.
        push(64'h00, 2'b00, 0, 4'd5); push(64'h11, 2'b00, 0, 4'd5);
        push(64'h22, 2'b00, 0, 4'd5); push(64'h33, 2'b00, 1, 4'd5);
        start = hs_count;
        send_ar(BASE, 4'd5, 8'd3, 3'd3, 2'b01, t);
        fv = -1;
        for (int k = 0; k < 30; k++) begin
            if (axi.rvalid) begin
                fv = cyc;
                break;
            end
            tick();
        end
        chk("first_latency", 64'(fv - t), 64'(1 + D));
        wait_burst(start, 4);
        chk("burst_span", 64'(last_hs_cyc - t), 64'(D + 4));

        // WRAP from BASE+0x10.
        push(64'h22, 2'b00, 0, 4'd6); push(64'h33, 2'b00, 0, 4'd6);
        push(64'h00, 2'b00, 0, 4'd6); push(64'h11, 2'b00, 1, 4'd6);
        start = hs_count;
        send_ar(BASE + 32'h10, 4'd6, 8'd3, 3'd3, 2'b10, t);
        wait_burst(start, 4);

        // INCR with rready backpressure.
        push(64'h00, 2'b00, 0, 4'd7); push(64'h11, 2'b00, 0, 4'd7);
        push(64'h22, 2'b00, 0, 4'd7); push(64'h33, 2'b00, 1, 4'd7);
        start = hs_count;
        tog_ph = 0;
        toggle = 1'b1;
        send_ar(BASE, 4'd7, 8'd3, 3'd3, 2'b01, t);
        wait_burst(start, 4);
        toggle = 1'b0;
        axi.rready = 1'b1;
        repeat (3) tick();
        chk("stall_hs_count", 64'(hs_count - start), 64'd4);

        // Error bursts.
        push(64'h0, 2'b10, 0, 4'd1); push(64'h0, 2'b10, 1, 4'd1);
        start = hs_count;
        send_ar(BASE - 32'd8, 4'd1, 8'd1, 3'd3, 2'b01, t);
        wait_burst(start, 2);

        push(64'h0, 2'b10, 0, 4'd2); push(64'h0, 2'b10, 0, 4'd2); push(64'h0, 2'b10, 1, 4'd2);
        start = hs_count;
        send_ar(BASE, 4'd2, 8'd2, 3'd3, 2'b10, t);
        wait_burst(start, 3);

        push(64'hCAFE_0000_0000_1022, 2'b00, 0, 4'd4);
        push(64'hCAFE_0000_0000_1023, 2'b00, 0, 4'd4);
        push(64'h0, 2'b10, 0, 4'd4); push(64'h0, 2'b10, 1, 4'd4);
        start = hs_count;
        send_ar(BASE + 32'd1022 * 32'd8, 4'd4, 8'd3, 3'd3, 2'b01, t);
        wait_burst(start, 4);

        // FIXED with a concurrent backdoor write to the same word.
        push(64'h11, 2'b00, 0, 4'd9); push(64'h11, 2'b00, 0, 4'd9); push(64'hAA, 2'b00, 1, 4'd9);
        start = hs_count;
        send_ar(BASE + 32'd8, 4'd9, 8'd2, 3'd3, 2'b00, t);
        tick();
        tick();
        init_we = 1'b1; init_idx = 10'd1; init_wdata = 64'hAA;
        tick();
        init_we = 1'b0;
        wait_burst(start, 3);

        // Reset during the second beat, then a fresh burst.
        push(64'h00, 2'b00, 0, 4'd3); push(64'hAA, 2'b00, 0, 4'd3);
        push(64'h22, 2'b00, 0, 4'd3); push(64'h33, 2'b00, 1, 4'd3);
        start = hs_count;
        send_ar(BASE, 4'd3, 8'd3, 3'd3, 2'b01, t);
        for (int k = 0; k < 30; k++) begin
            if (hs_count >= start + 1) break;
            tick();
        end
        rst = 1'b1;
        #1;
        chk("midrst_rvalid", {63'd0, axi.rvalid}, 64'd0);
        chk("midrst_arready", {63'd0, axi.arready}, 64'd1);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        push(64'h33, 2'b00, 0, 4'd8); push(64'h22, 2'b00, 1, 4'd8);
        start = hs_count;
        send_ar(BASE + 32'h18, 4'd8, 8'd1, 3'd3, 2'b10, t);
        wait_burst(start, 2);

        repeat (3) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_23060136_axi_rd_responder.md
# ysyx_23060136_axi_rd_responder

AXI4 read-only burst responder that answers the instruction-fetch read channel (ar*/r*) driven by the IFU I-cache refill path through the arbiter. It holds a word-addressed 64-bit memory array with a backdoor preload port, and serves INCR, FIXED and WRAP bursts with a programmable first-beat latency and full `rready` backpressure. It is used as the memory model behind the arbiter in core-level benches and as the on-chip boot ROM/SRAM responder.

## Interface
Parameters:
- `DEPTH`, 1024: number of 64-bit words; power of two.
- `BASE_ADDR`, 32'h3000_0000: byte address of word 0.
- `RD_DELAY`, 2: idle cycles between AR handshake and first R beat (0..15).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; one clock; reset is asynchronous and active-high.
- `arvalid` in 1 / `arready` out 1: AR handshake.
- `araddr` in 32; `arid` in 4; `arlen` in 8; `arsize` in 3; `arburst` in 2: AR payload.
- `rvalid` out 1 / `rready` in 1: R handshake.
- `rdata` out 64; `rresp` out 2; `rlast` out 1; `rid` out 4: R payload.
- `init_we` in 1; `init_idx` in log2(DEPTH); `init_wdata` in 64: backdoor word write, 1 cycle.

## Operation
- FSM states: IDLE, WAIT, BURST.
- IDLE: `arready`=1. On `arvalid&&arready`, latch addr/id/len/size/burst, compute the error flag, and load the delay counter with `RD_DELAY`. Go to WAIT; if `RD_DELAY`=0, go directly to BURST.
- WAIT: `arready`=0. Decrement the counter each cycle. At 0, go to BURST.
- BURST: `arready`=0. Beat register (`rvalid`, `rdata`, `rresp`, `rlast`) is loaded when empty or when the current beat handshakes (`rvalid&&rready`). Load continues while beats issued < `arlen`+1.
- After the beat with `rlast`=1 handshakes, go to IDLE.
- Payload (`rdata`/`rresp`/`rlast`/`rid`) is held stable while `rvalid&&!rready`.
- Word index = `(addr-BASE_ADDR)>>3`, low log2(DEPTH) bits.
- `rdata` is the full 64-bit word containing the address; narrow sizes are not lane-shifted.
- Address update per beat:
  - FIXED (00): unchanged.
  - INCR (01): `addr += 1<<arsize`, 32-bit wrap.
  - WRAP (10): `addr = (addr & ~mask) | ((addr + (1<<arsize)) & mask)`, with `mask = ((arlen+1)<<arsize)-1`.
- Error (SLVERR, `rresp`=2'b10, `rdata`=0) applies to a whole burst when any of these holds:
  - start address is outside [BASE, BASE+DEPTH*8);
  - `arsize`>3;
  - `arburst`=11;
  - WRAP with `arlen` not in {1,3,7,15};
  - WRAP with an unaligned start address.
- Even on error, exactly `arlen`+1 beats are returned with `rlast` on the final beat. Otherwise `rresp`=00.
- INCR bursts that run past the top of the array return SLVERR on the overflowing beats only.
- `init_we` writes take effect next cycle. A simultaneous read of the same index returns the old word.

## Timing
- Reset values: state IDLE, `arready`=1, `rvalid`=0, `rlast`=0, `rresp`=0, `rdata`=0, `rid`=0, counters 0. Memory contents are not reset.
- AR handshake at cycle T: first `rvalid` at T+1+`RD_DELAY`.
- With `rready` held high, one beat per cycle. A burst of N beats occupies T+1+`RD_DELAY` .. T+`RD_DELAY`+N.
- Final handshake at cycle F: `arready`=1 at F+1. Next AR accepted at F+1 earliest; no AR/R overlap.
- `rready` low: beat holds indefinitely; no beat lost or duplicated.
- `rst` asserted mid-burst: outputs go to reset values immediately; the burst is abandoned.

## Structure
- Shared package `ysyx_23060136_DEFINES.sv` holds:
  - AXI burst encodings `BURST_FIXED/INCR/WRAP`;
  - response codes `RESP_OKAY/SLVERR`;
  - the FSM state enum.
- One natural sub-module, `ysyx_23060136_axi_addr_gen`: combinational next-address and WRAP-legality calculation, reusable by the data-side responder.

## Test plan
- Preload words 0..7 = `i*0x11`; INCR `araddr`=BASE, `arlen`=3, `arsize`=3, `RD_DELAY`=2, `rready`=1 → beats at T+3..T+6 with data 0x00,0x11,0x22,0x33, `rlast` on the 4th, `rid`=`arid`, `rresp`=00.
- WRAP `araddr`=BASE+0x10, `arlen`=3, `arsize`=3 → data 0x22,0x33,0x00,0x11.
- Same INCR burst with `rready` toggling 1,0,0,1,… → each beat held stable while stalled; exactly 4 handshakes, last with `rlast`; `arready` returns the cycle after.
- `araddr`=BASE-8, `arlen`=1 → 2 beats, `rresp`=10, `rdata`=0, `rlast` on the 2nd; WRAP with `arlen`=2 → 3 SLVERR beats.
- FIXED `araddr`=BASE+8, `arlen`=2 → 0x11 three times. A concurrent `init_we` to idx 1 with 0xAA → the beat that reads idx 1 in the same cycle as the write returns 0x11; every beat read on later cycles returns 0xAA.
- Assert `rst` during the 2nd beat → `rvalid`=0 and `arready`=1 immediately; a new burst after release completes correctly.
